reset_release_sequencer: RTL

Converts the asynchronous, active-high system reset into glitch-free, synchronously released resets for NUM_DOMAINS downstream blocks in the clk domain. Assertion is immediate and asynchronous; release is synchronized, held for a programmable interval, then staggered domain by domain. Deassertion is thereby clean for every asynchronous-reset flop fed by this block. It sits between the board reset input and all async-reset registers in the clk domain, and also accepts a synchronous soft-reset request.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_sync.sv | 34 +++
 rtl/reset_release_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset release sequencer
// and its synchronizer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  // Wide enough to hold the larger of the two intervals without wrapping.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int m;
    m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int num_domains);
    return (num_domains > 1) ? $clog2(num_domains) : 1;
  endfunction

  function automatic bit params_legal(input int sync_stages, input int hold_cycles,
                                      input int num_domains, input int stage_gap);
    return (sync_stages >= 2) && (hold_cycles >= 1) &&
           (num_domains >= 1) && (stage_gap >= 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert, sync-deassert reset synchronizer; output follows reset
// immediately and releases SYNC_STAGES edges after reset falls.
module reset_sync
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_rst
);

  if (SYNC_STAGES < 2) begin : g_param_check
    $fatal(1, "reset_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_rst = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Turns the board reset into per-domain resets that assert asynchronously and
// release synchronously, after a hold interval, one domain at a time.
//
// state   | meaning
// SYNC    | waiting for the synchronized board reset to release
// HOLD    | all domains held, counting HOLD_CYCLES (restarted by soft_req)
// RELEASE | one domain released every STAGE_GAP cycles, ascending index
// RUN     | all domains released
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 4,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic                   busy
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = idx_width(NUM_DOMAINS);

  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

  if (!params_legal(SYNC_STAGES, HOLD_CYCLES, NUM_DOMAINS, STAGE_GAP)) begin : g_param_check
    $fatal(1, "reset_release_sequencer: illegal parameter combination");
  end

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   soft_q, soft_d;
  logic                   sync_rst;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk     (clk),
    .reset   (reset),
    .sync_rst(sync_rst)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    soft_d  = 1'b0;

    if (soft_req && (state_q != SYNC)) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      soft_d  = 1'b1;
    end else begin
      case (state_q)
        SYNC: begin
          if (!sync_rst) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          // The first edge after soft_req drops plays the role of HOLD entry.
          if (soft_q) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d    = '0;
            rst_d[0] = 1'b0;
            if (NUM_DOMAINS == 1) begin
              state_d = RUN;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            rst_d = rst_q & ~(DOM_ONE << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          rst_d = '0;
        end
        default: begin
          state_d = SYNC;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
        end
      endcase
    end

    // ready follows a full cycle in RUN; busy covers the handoff edge so the
    // two never drop out together.
    ready_d = (state_q == RUN) && (state_d == RUN);
    busy_d  = (state_d != SYNC) && !ready_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      soft_q  <= soft_d;
    end
  end

  assign rst_out = rst_q;
  assign ready   = ready_q;
  assign busy    = busy_q;

endmodule
